// File: rtl/pulse_to_level_stretcher.sv
// Stretches a single-cycle strobe into a level held for Hold_Cycles clocks, with
// optional retrigger and a post-level lockout gap; flags completion and dropped strobes.
module pulse_to_level_stretcher #(
  parameter int unsigned CNT_W      = 16,
  parameter bit          RETRIGGER  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             CLK,
  input  logic             Reset_N,
  input  logic             Pulse_In,
  input  logic [CNT_W-1:0] Hold_Cycles,
  output logic             Level_Out,
  output logic             Busy,
  output logic             Done_Pulse,
  output logic             Dropped_Pulse
);

  localparam int unsigned      GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] load_val;

  // A zero length still yields a one-cycle level.
  assign load_val = (Hold_Cycles == '0) ? '0 : Hold_Cycles - CNT_W'(1);

  always_ff @(posedge CLK or negedge Reset_N) begin
    if (!Reset_N) begin
      state         <= IDLE;
      cnt           <= '0;
      gap_cnt       <= '0;
      Level_Out     <= 1'b0;
      Busy          <= 1'b0;
      Done_Pulse    <= 1'b0;
      Dropped_Pulse <= 1'b0;
    end else begin
      Done_Pulse    <= 1'b0;
      Dropped_Pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (Pulse_In) begin
            state     <= HOLD;
            cnt       <= load_val;
            Level_Out <= 1'b1;
            Busy      <= 1'b1;
          end
        end
        HOLD: begin
          if (Pulse_In && RETRIGGER) begin
            cnt <= load_val;
          end else begin
            // A dropped strobe does not disturb the countdown, even on its last cycle.
            if (Pulse_In) Dropped_Pulse <= 1'b1;
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              Level_Out  <= 1'b0;
              Done_Pulse <= 1'b1;
              if (GAP_CYCLES > 0) begin
                state   <= GAP;
                gap_cnt <= GAP_LOAD;
              end else begin
                state <= IDLE;
                Busy  <= 1'b0;
              end
            end
          end
        end
        GAP: begin
          Dropped_Pulse <= Pulse_In;
          if (gap_cnt == '0) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          Level_Out <= 1'b0;
          Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
